// File: rtl/wb_stage_if.sv
// MEM -> WB boundary bundle: memory-stage inputs, pipeline control, and
// the write-back outputs (register-file write port, forwarding source,
// retire counter).
interface wb_stage_if #(
    parameter int RETIRE_W = 32
) ();
    logic                stall;
    logic                flush;
    logic [31:0]         IRM;
    logic [31:0]         PCM;
    logic [31:0]         ALUout;
    logic [31:0]         DMout;
    logic [31:0]         IRW;
    logic [31:0]         PCW;
    logic                RegWrite;
    logic [4:0]          WriteAddr;
    logic [31:0]         WriteData;
    logic [RETIRE_W-1:0] retire_cnt;

    // Memory-stage / pipeline-control side
    modport master (
        output stall, flush, IRM, PCM, ALUout, DMout,
        input  IRW, PCW, RegWrite, WriteAddr, WriteData, retire_cnt
    );

    // Write-back stage side
    modport slave (
        input  stall, flush, IRM, PCM, ALUout, DMout,
        output IRW, PCW, RegWrite, WriteAddr, WriteData, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB pipeline register, sub-word load
// extraction, register-file write port and retired-instruction counter.
module wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    logic [31:0]         ir_p0;
    logic [31:0]         pc_p0;
    logic [31:0]         aow_p0;
    logic [31:0]         drw_p0;
    logic [RETIRE_W-1:0] retire_q;

    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] byte_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        dec_we;
    logic [4:0]  dec_addr;
    logic [31:0] dec_data;
    logic        wr_en;

    // Byte extension for lb (signed) / lbu (unsigned)
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  sb;
        logic signed [31:0] sw;
        sb = b;
        sw = 32'(sb);
        return sgn ? 32'(sw) : {24'b0, b};
    endfunction

    // Halfword extension for lh (signed) / lhu (unsigned)
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sh = h;
        sw = 32'(sh);
        return sgn ? 32'(sw) : {16'b0, h};
    endfunction

    // ---- MEM/WB register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            ir_p0  <= '0;
            pc_p0  <= '0;
            aow_p0 <= '0;
            drw_p0 <= '0;
        end else if (!bus.stall) begin
            ir_p0  <= bus.IRM;
            pc_p0  <= bus.PCM;
            aow_p0 <= bus.ALUout;
            drw_p0 <= bus.DMout;
        end
    end

    // Count non-bubble instructions entering write-back; wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
        end else if (!bus.flush && !bus.stall && (bus.IRM != 32'd0)) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    // ---- WB decode: destination and write value from the held instruction
    assign op      = ir_p0[31:26];
    assign func    = ir_p0[5:0];
    assign rt      = ir_p0[20:16];
    assign rd      = ir_p0[15:11];
    assign byte_sh = drw_p0 >> {aow_p0[1:0], 3'b000};
    assign ld_byte = byte_sh[7:0];
    // Misaligned halfword: bit 0 of the address is deliberately ignored
    assign ld_half = aow_p0[1] ? drw_p0[31:16] : drw_p0[15:0];

    // Decode which register is written and with what
    always_comb begin
        dec_we   = 1'b0;
        dec_addr = 5'd0;
        dec_data = 32'd0;
        case (op)
            OP_RTYPE: begin
                if (func == FN_ADDU || func == FN_SUBU) begin
                    dec_we   = 1'b1;
                    dec_addr = rd;
                    dec_data = aow_p0;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_we   = 1'b1;
                dec_addr = rt;
                dec_data = aow_p0;
            end
            OP_LW: begin
                dec_we   = 1'b1;
                dec_addr = rt;
                dec_data = drw_p0;
            end
            OP_LB, OP_LBU: begin
                dec_we   = 1'b1;
                dec_addr = rt;
                dec_data = ext_byte(ld_byte, op == OP_LB);
            end
            OP_LH, OP_LHU: begin
                dec_we   = 1'b1;
                dec_addr = rt;
                dec_data = ext_half(ld_half, op == OP_LH);
            end
            OP_JAL: begin
                dec_we   = 1'b1;
                dec_addr = 5'd31;
                dec_data = pc_p0 + 32'd8;
            end
            default: begin
                dec_we   = 1'b0;
            end
        endcase
    end

    // Writes to $0 are dropped and the write port then reads all zero
    assign wr_en          = dec_we && (dec_addr != 5'd0);
    assign bus.RegWrite   = wr_en;
    assign bus.WriteAddr  = wr_en ? dec_addr : 5'd0;
    assign bus.WriteData  = wr_en ? dec_data : 32'd0;
    assign bus.IRW        = ir_p0;
    assign bus.PCW        = pc_p0;
    assign bus.retire_cnt = retire_q;

`ifndef SYNTHESIS
    // Trace every register-file write
    always_ff @(posedge clk) begin
        if (bus.RegWrite) begin
            $display("@%h: $%d <= %h", bus.PCW, bus.WriteAddr, bus.WriteData);
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus randomized traffic
// against a behavioural model of the MEM/WB register and WB decode.
module tb_wb_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if #(.RETIRE_W(32)) bus ();
    wb_stage_if #(.RETIRE_W(4))  bus4 ();

    assign bus4.stall  = bus.stall;
    assign bus4.flush  = bus.flush;
    assign bus4.IRM    = bus.IRM;
    assign bus4.PCM    = bus.PCM;
    assign bus4.ALUout = bus.ALUout;
    assign bus4.DMout  = bus.DMout;

    wb_stage #(.RETIRE_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    wb_stage #(.RETIRE_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    int checks = 0;
    int errors = 0;

    // model of the MEM/WB contents and retire count
    logic [31:0] m_ir, m_pc, m_aow, m_drw, m_cnt;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;

    function automatic logic [31:0] mk_i(input int op, input int rt, input int imm);
        return (op << 26) | (rt << 16) | (imm & 32'hFFFF);
    endfunction

    function automatic logic [31:0] mk_r(input int rd, input int fn);
        return (rd << 11) | fn;
    endfunction

    // Expected write port from the instruction-set rules
    function automatic void model_wb(input logic [31:0] ir, input logic [31:0] pc,
                                     input logic [31:0] aow, input logic [31:0] drw,
                                     output logic we, output logic [4:0] a,
                                     output logic [31:0] d);
        int unsigned op, fn, rt, rd, b, h;
        op = ir >> 26; fn = ir & 63; rt = (ir >> 16) & 31; rd = (ir >> 11) & 31;
        we = 0; a = 0; d = 0;
        if (op == 0 && (fn == 33 || fn == 35)) begin we = 1; a = 5'(rd); d = aow; end
        else if (op == 13 || op == 15) begin we = 1; a = 5'(rt); d = aow; end
        else if (op == 35) begin we = 1; a = 5'(rt); d = drw; end
        else if (op == 32 || op == 36) begin
            b = (drw >> (8 * (aow % 4))) & 255;
            we = 1; a = 5'(rt);
            d = (op == 32 && b >= 128) ? (b | 32'hFFFFFF00) : b;
        end else if (op == 33 || op == 37) begin
            h = ((aow / 2) % 2 == 1) ? (drw >> 16) : (drw & 65535);
            we = 1; a = 5'(rt);
            d = (op == 33 && h >= 32768) ? (h | 32'hFFFF0000) : h;
        end else if (op == 3) begin we = 1; a = 31; d = pc + 8; end
        if (a == 0) we = 0;
        if (!we) begin a = 0; d = 0; end
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle
    task automatic step(input logic s, input logic f, input logic r,
                        input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] dm);
        bus.stall = s; bus.flush = f; reset = r;
        bus.IRM = ir; bus.PCM = pc; bus.ALUout = alu; bus.DMout = dm;
        @(posedge clk);
        if (r || f) begin
            m_ir = 0; m_pc = 0; m_aow = 0; m_drw = 0;
        end else if (!s) begin
            m_ir = ir; m_pc = pc; m_aow = alu; m_drw = dm;
        end
        if (r) m_cnt = 0;
        else if (!f && !s && ir != 0) m_cnt = m_cnt + 1;
        #1;
        model_wb(m_ir, m_pc, m_aow, m_drw, e_we, e_a, e_d);
    endtask

    task automatic test_reset();
        step(0, 0, 1, 32'h8C05_0010, 32'h100, 32'h10, 32'h1234);
        step(1, 1, 1, 32'h8C05_0010, 32'h100, 32'h10, 32'h1234);
        checks++; if (bus.IRW !== 32'd0) begin errors++; $display("FAIL reset_irw got %h exp 0", bus.IRW); end
        checks++; if (bus.PCW !== 32'd0) begin errors++; $display("FAIL reset_pcw got %h exp 0", bus.PCW); end
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.RegWrite); end
        checks++; if (bus.WriteAddr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.WriteAddr); end
        checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.WriteData); end
        checks++; if (bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.retire_cnt); end
    endtask

    task automatic test_word_jal();
        step(0, 0, 0, mk_i(35, 5, 16), 32'h200, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData);
        end
        step(0, 0, 0, mk_i(3, 0, 0), 32'h3000, 32'h0, 32'h0);
        checks++;
        if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b1, 5'd31, 32'h3008}) begin
            errors++; $display("FAIL jal got we=%b a=%0d d=%h exp we=1 a=31 d=3008",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData);
        end
        checks++; if (bus.PCW !== 32'h3000) begin errors++; $display("FAIL jal_pcw got %h exp 3000", bus.PCW); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] exp_lb [4];
        exp_lb[0] = 32'h00000001; exp_lb[1] = 32'h0000007F;
        exp_lb[2] = 32'hFFFFFFF1; exp_lb[3] = 32'hFFFFFF80;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, mk_i(32, 7, k), 32'h400, 32'h40 + k, 32'h80F17F01);
            checks++;
            if (bus.WriteData !== exp_lb[k] || bus.WriteAddr !== 5'd7) begin
                errors++; $display("FAIL lb_%0d got a=%0d d=%h exp a=7 d=%h",
                                   k, bus.WriteAddr, bus.WriteData, exp_lb[k]);
            end
        end
        step(0, 0, 0, mk_i(36, 8, 3), 32'h404, 32'h43, 32'h80F17F01);
        checks++; if (bus.WriteData !== 32'h00000080) begin errors++; $display("FAIL lbu_3 got %h exp 00000080", bus.WriteData); end
    endtask

    task automatic test_half_loads();
        step(0, 0, 0, mk_i(33, 9, 2), 32'h500, 32'h52, 32'h8001FFFE);
        checks++; if (bus.WriteData !== 32'hFFFF8001) begin errors++; $display("FAIL lh_hi got %h exp ffff8001", bus.WriteData); end
        step(0, 0, 0, mk_i(37, 9, 0), 32'h504, 32'h50, 32'h8001FFFE);
        checks++; if (bus.WriteData !== 32'h0000FFFE) begin errors++; $display("FAIL lhu_lo got %h exp 0000fffe", bus.WriteData); end
        step(0, 0, 0, mk_i(33, 9, 3), 32'h508, 32'h53, 32'h8001FFFE);
        checks++; if (bus.WriteData !== 32'hFFFF8001) begin errors++; $display("FAIL lh_misaligned got %h exp ffff8001", bus.WriteData); end
        step(0, 0, 0, mk_i(33, 9, 1), 32'h50C, 32'h51, 32'h8001FFFE);
        checks++; if (bus.WriteData !== 32'hFFFFFFFE) begin errors++; $display("FAIL lh_lo_odd got %h exp fffffffe", bus.WriteData); end
    endtask

    task automatic test_no_write();
        step(0, 0, 0, mk_r(0, 33), 32'h600, 32'h1234, 32'h0);
        checks++;
        if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== 38'd0) begin
            errors++; $display("FAIL addu_r0 got we=%b a=%0d d=%h exp all 0",
                               bus.RegWrite, bus.WriteAddr, bus.WriteData);
        end
        step(0, 0, 0, mk_i(43, 4, 8), 32'h604, 32'h8, 32'h55);
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL sw_we got %b exp 0", bus.RegWrite); end
        step(0, 0, 0, mk_i(4, 4, 8), 32'h608, 32'h8, 32'h55);
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL beq_we got %b exp 0", bus.RegWrite); end
    endtask

    task automatic test_control();
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, mk_r(1, 33), 32'h700, 32'h11, 0);
        step(0, 0, 0, mk_r(2, 33), 32'h704, 32'h22, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, mk_r(3, 33), 32'h708, 32'h33, 0);
            checks++;
            if ({bus.RegWrite, bus.WriteAddr, bus.WriteData} !== {1'b1, 5'd2, 32'h22}) begin
                errors++; $display("FAIL stall_hold_%0d got we=%b a=%0d d=%h exp we=1 a=2 d=22",
                                   i, bus.RegWrite, bus.WriteAddr, bus.WriteData);
            end
        end
        step(1, 1, 0, mk_r(3, 33), 32'h708, 32'h33, 0);
        checks++; if (bus.IRW !== 32'd0 || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL flush_bubble got ir=%h we=%b exp ir=0 we=0", bus.IRW, bus.RegWrite); end
        checks++; if (bus.retire_cnt !== 32'd2) begin errors++; $display("FAIL ctrl_cnt got %0d exp 2", bus.retire_cnt); end
        step(0, 0, 0, mk_r(3, 33), 32'h708, 32'h33, 0);
        step(1, 0, 1, mk_r(4, 33), 32'h70C, 32'h44, 0);
        checks++;
        if (bus.retire_cnt !== 32'd0 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL reset_stall got cnt=%0d we=%b exp cnt=0 we=0", bus.retire_cnt, bus.RegWrite);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int ops[12] = '{0, 0, 13, 15, 35, 32, 36, 33, 37, 3, 43, 4};
        int op;
        logic [31:0] ir;
        op = ops[$urandom_range(11)];
        ir = $urandom;
        ir[31:26] = 6'(op);
        if (op == 0) ir[5:0] = ($urandom_range(2) == 0) ? 6'd33 : (($urandom_range(1) == 0) ? 6'd35 : 6'd8);
        if ($urandom_range(9) == 0) ir = 32'd0;
        return ir;
    endfunction

    task automatic test_random();
        logic s, f, r;
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(5) == 0);
            f = ($urandom_range(9) == 0);
            r = ($urandom_range(49) == 0);
            step(s, f, r, rand_instr(), $urandom, $urandom, $urandom);
            checks++;
            if ({bus.IRW, bus.PCW, bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.retire_cnt}
                !== {m_ir, m_pc, e_we, e_a, e_d, m_cnt}) begin
                errors++;
                $display("FAIL rand_%0d got ir=%h pc=%h we=%b a=%0d d=%h cnt=%0d exp ir=%h pc=%h we=%b a=%0d d=%h cnt=%0d",
                         i, bus.IRW, bus.PCW, bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.retire_cnt,
                         m_ir, m_pc, e_we, e_a, e_d, m_cnt);
            end
            checks++;
            if (bus4.retire_cnt !== m_cnt[3:0]) begin
                errors++; $display("FAIL rand_cnt4_%0d got %0d exp %0d", i, bus4.retire_cnt, m_cnt[3:0]);
            end
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, mk_r(5, 33) | 32'h0300_0000, 32'h800 + i * 4, i, 0);
        end
        checks++; if (bus4.retire_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got %0d exp 1", bus4.retire_cnt); end
        checks++; if (bus.retire_cnt !== 32'd17) begin errors++; $display("FAIL wrap_cnt32 got %0d exp 17", bus.retire_cnt); end
    endtask

    initial begin
        m_ir = 0; m_pc = 0; m_aow = 0; m_drw = 0; m_cnt = 0;
        test_reset();
        test_word_jal();
        test_byte_loads();
        test_half_loads();
        test_no_write();
        test_control();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline, directly downstream of the data-memory stage. It latches the memory stage's instruction, PC, ALU result and data-memory read word into the MEM/WB pipeline register, extracts and extends sub-word load data, and drives the register-file write port (enable, address, data). It also exposes the write-back value for the forwarding unit and keeps a count of retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.

- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: reset is synchronous and active-high; clock is `clk`.
- `stall` input 1: hold the MEM/WB register contents for this cycle.
- `flush` input 1: load a bubble into MEM/WB for this cycle.
- `IRM` input 32: instruction currently in the memory stage.
- `PCM` input 32: PC of `IRM`.
- `ALUout` input 32: memory-stage ALU result, which is also the data address.
- `DMout` input 32: word read from data memory at `ALUout[11:2]`.
- `IRW` output 32: instruction held in write-back.
- `PCW` output 32: PC of `IRW`.
- `RegWrite` output 1: register-file write enable.
- `WriteAddr` output 5: destination register.
- `WriteData` output 32: value written; also used as the forwarding source.
- `retire_cnt` output RETIRE_W: number of non-bubble instructions that have entered write-back.

## Operation
- The MEM/WB register holds IRW, PCW, AOW (the ALU result) and DRW (the memory word). Update priority is reset, then flush, then stall, then normal load.
  - reset or flush: all four registers are set to 0. The bubble is IRW = 0, which is `sll $0` and produces no write.
  - stall: all registers hold their values.
  - normal: IRW←IRM, PCW←PCM, AOW←ALUout, DRW←DMout.
- Decode of IRW is combinational. `op` = [31:26], `func` = [5:0].
  - R-type (op 000000), addu (100001) or subu (100011): dest = rd, data = AOW.
  - ori (001101) and lui (001111): dest = rt, data = AOW.
  - lw (100011): dest = rt, data = DRW.
  - lb (100000) and lbu (100100): the byte is selected by AOW[1:0], little-endian, so byte k = DRW[8k+7:8k]. lb sign-extends the byte; lbu zero-extends it.
  - lh (100001) and lhu (100101): the halfword is selected by AOW[1]; 0 selects DRW[15:0] and 1 selects DRW[31:16]. lh sign-extends; lhu zero-extends.
  - jal (000011): dest = 31, data = PCW + 8 (32-bit, wraps).
  - Everything else (sw, beq, jr, unknown): no write, with WriteAddr = 0 and WriteData = 0.
- RegWrite = (decoded write) AND (WriteAddr ≠ 0). A write to $0 is suppressed, and WriteAddr and WriteData then read 0.
- A halfword access with AOW[0] = 1 is not trapped: it uses AOW[1] and ignores AOW[0].
- `retire_cnt` increments by 1 on each rising edge that performs a normal load with IRM ≠ 0.
  - It does not increment on stall, flush or reset.
  - Reset clears it to 0.
  - It wraps modulo 2^RETIRE_W.
- On every cycle where RegWrite = 1, simulation prints `$display("@%h: $%d <= %h", PCW, WriteAddr, WriteData)`. The print is guarded by `ifndef SYNTHESIS`.

## Timing
- Latency is one cycle: values present on IRM, ALUout and DMout before edge n appear decoded on the outputs after edge n.
- The register file must write on the next rising edge, using RegWrite, WriteAddr and WriteData. The forwarding path samples WriteData combinationally in the same cycle.
- Reset values: IRW = 0, PCW = 0, RegWrite = 0, WriteAddr = 0, WriteData = 0, retire_cnt = 0.
- reset together with flush or stall: reset wins. flush together with stall: flush wins, and the bubble is inserted.
- Reset asserted while an instruction is in write-back: that instruction's write is not performed on any edge after the reset edge. retire_cnt does not count it again.
- A stall lasting N cycles holds RegWrite, WriteAddr and WriteData constant for N+1 cycles. The register file may rewrite the same value; this is harmless.
- DMout must be stable before the edge. The data-memory read is combinational from ALUout.

## Test plan
- Word and jal writes: IRM = lw $5, ALUout = 0x10, DMout = 0xDEADBEEF. One cycle later: RegWrite = 1, WriteAddr = 5, WriteData = 0xDEADBEEF. Then jal with PCM = 0x3000, which gives WriteAddr = 31 and WriteData = 0x3008.
- Byte loads: DMout = 0x80F17F01 with ALUout[1:0] = 0..3.
  - lb gives 0x00000001, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80.
  - lbu with ALUout[1:0] = 3 gives 0x00000080.
- Halfword loads: DMout = 0x8001FFFE.
  - lh with AOW[1] = 1 gives 0xFFFF8001.
  - lhu with AOW[1] = 0 gives 0x0000FFFE.
- No-write cases: addu $0 gives RegWrite = 0 and WriteData = 0. sw and beq give RegWrite = 0.
- Control priority and counter:
  - Issue 3 addu. Stall on the 2nd for 2 cycles, then flush on the 3rd.
  - Expected: retire_cnt = 2, and the outputs hold during the stall.
  - Asserting reset together with stall clears retire_cnt to 0 and RegWrite to 0.
- Counter wrap: with RETIRE_W = 4, retire 17 non-bubble instructions. Expected retire_cnt = 1.
